// File: rtl/tdm_demux_1_4.sv
// tdm_demux_1_4: registered 1:4 TDM demux; lanes chosen by a frame slot counter (mode=0) or sel (mode=1).
// Latency: one clock from accepted word to lane/out_valid update; all pulse outputs are one registered cycle.
// Backpressure: none; frame-mode words seen in IDLE without frame_start are dropped and counted. Option: TDM_DEMUX_PARITY_EN.
module tdm_demux_1_4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               frame_start,
  input  logic               mode,
  input  logic [1:0]         sel,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic               in_parity,
  output logic               parity_err,
`endif
  output logic [4*WIDTH-1:0] out,
  output logic [3:0]         out_valid,
  output logic               frame_done,
  output logic               frame_err,
  output logic [7:0]         drop_cnt
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic       state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic       wr_en;
  logic [1:0] wr_lane;
  logic       done_d;
  logic       err_d;
  logic       drop_d;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    wr_en   = 1'b0;
    wr_lane = 2'd0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    if (in_valid) begin
      if (mode) begin
        // Direct mode abandons any frame in progress without flagging it.
        wr_en   = 1'b1;
        wr_lane = sel;
        state_d = ST_IDLE;
        slot_d  = 2'd0;
      end else if (state_q == ST_IDLE) begin
        if (frame_start) begin
          wr_en   = 1'b1;
          wr_lane = 2'd0;
          slot_d  = 2'd1;
          state_d = ST_RUN;
        end else begin
          drop_d = 1'b1;
        end
      end else if (frame_start) begin
        // Resync: restart at slot 0 and stay in RUN.
        wr_en   = 1'b1;
        wr_lane = 2'd0;
        slot_d  = 2'd1;
        err_d   = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_lane = slot_q;
        slot_d  = slot_q + 2'd1;
        if (slot_q == 2'd3) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      slot_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_lane == 2'(k)) out[k*WIDTH +: WIDTH] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 4'b0000;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      out_valid  <= wr_en ? (4'b0001 << wr_lane) : 4'b0000;
      frame_done <= done_d;
      frame_err  <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else if (drop_d && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= wr_en && ((^in_data) != in_parity);
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Scoreboard bench for tdm_demux_1_4 at WIDTH=4; parity checks only when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux_1_4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        frame_start;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] out;
  logic [3:0]  out_valid;
  logic        frame_done;
  logic        frame_err;
  logic [7:0]  drop_cnt;
  logic        perr_w;
  logic        bad_par;
`ifdef TDM_DEMUX_PARITY_EN
  logic        in_parity;
  logic        parity_err;
  assign perr_w = parity_err;
`else
  assign perr_w = 1'b0;
`endif

  tdm_demux_1_4 #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .frame_start (frame_start),
    .mode        (mode),
    .sel         (sel),
`ifdef TDM_DEMUX_PARITY_EN
    .in_parity   (in_parity),
    .parity_err  (parity_err),
`endif
    .out         (out),
    .out_valid   (out_valid),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0]  exp_lanes [4];
  logic [7:0]  exp_drop;
  logic [30:0] sbq [$];
  logic [30:0] e;

  function automatic logic [30:0] mk(input logic [3:0] ov, input logic d, input logic er, input logic pe);
    return {exp_lanes[3], exp_lanes[2], exp_lanes[1], exp_lanes[0], ov, d, er, exp_drop, pe};
  endfunction

  function automatic logic [30:0] snap();
    return {out, out_valid, frame_done, frame_err, drop_cnt, perr_w};
  endfunction

  task automatic send(input logic [3:0] d, input logic fs, input logic m, input logic [1:0] s);
    in_valid    = 1'b1;
    in_data     = d;
    frame_start = fs;
    mode        = m;
    sel         = s;
`ifdef TDM_DEMUX_PARITY_EN
    in_parity   = (^d) ^ bad_par;
`endif
  endtask

  task automatic bump_drop();
    if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
  endtask

  task automatic tick(output logic [30:0] ex);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    frame_start = 1'b0;
    if (sbq.size() != 0) ex = sbq.pop_front();
    else ex = '1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++;
    if (snap() !== mk(4'b0000, 1'b0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_initial: got %h expected %h", snap(), mk(4'b0000, 1'b0, 1'b0, 1'b0));
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    send(4'h5, 1'b1, 1'b0, 2'd0);
    exp_lanes[0] = 4'h5;
    sbq.push_back(mk(4'b0001, 1'b0, 1'b0, 1'b0));
    tick(e);
    vectors++;
    if (snap() !== e) begin
      miscompares++;
      $display("FAIL reset_pre_w0: got %h expected %h", snap(), e);
    end
    send(4'h6, 1'b0, 1'b0, 2'd0);
    exp_lanes[1] = 4'h6;
    sbq.push_back(mk(4'b0010, 1'b0, 1'b0, 1'b0));
    tick(e);
    vectors++;
    if (snap() !== e) begin
      miscompares++;
      $display("FAIL reset_pre_w1: got %h expected %h", snap(), e);
    end
    // Async reset mid-frame, away from any clock edge.
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) exp_lanes[k] = 4'h0;
    exp_drop = 8'd0;
    vectors++;
    if (snap() !== mk(4'b0000, 1'b0, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL reset_midframe: got %h expected %h", snap(), mk(4'b0000, 1'b0, 1'b0, 1'b0));
    end
    @(negedge clk) rst = 1'b0;
    send(4'h9, 1'b0, 1'b0, 2'd2);
    bump_drop();
    sbq.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0));
    tick(e);
    vectors++;
    if (snap() !== e || drop_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL reset_drop_after: got %h expected %h (drop_cnt %0d want 1)", snap(), e, drop_cnt);
    end
  endtask

  task automatic test_direct();
    logic [3:0] v;
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 4; s++) begin
        v = (p == 0) ? 4'(8 + s) : 4'(s);
        send(v, s[0], 1'b1, 2'(s));
        exp_lanes[s] = v;
        sbq.push_back(mk(4'b0001 << s, 1'b0, 1'b0, 1'b0));
        tick(e);
        vectors++;
        if (snap() !== e) begin
          miscompares++;
          $display("FAIL direct_p%0d_s%0d: got %h expected %h", p, s, snap(), e);
        end
      end
    end
  endtask

  task automatic test_frame();
    logic [3:0] w [4];
    w[0] = 4'hA; w[1] = 4'hB; w[2] = 4'hC; w[3] = 4'hD;
    for (int k = 0; k < 4; k++) begin
      send(w[k], k == 0, 1'b0, 2'd3);
      exp_lanes[k] = w[k];
      sbq.push_back(mk(4'b0001 << k, k == 3, 1'b0, 1'b0));
      for (int g = 0; g < 2; g++) sbq.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0));
      for (int c = 0; c < 3; c++) begin
        tick(e);
        vectors++;
        if (snap() !== e) begin
          miscompares++;
          $display("FAIL frame_w%0d_c%0d: got %h expected %h", k, c, snap(), e);
        end
      end
    end
    vectors++;
    if (out !== 16'hDCBA) begin
      miscompares++;
      $display("FAIL frame_lanes: got %h expected dcba", out);
    end
  endtask

  task automatic test_resync();
    logic [3:0] w [6];
    logic [1:0] ln [6];
    logic       fs [6];
    w[0] = 4'h3; w[1] = 4'h1; w[2] = 4'h2; w[3] = 4'h7; w[4] = 4'h4; w[5] = 4'h5;
    ln[0] = 2'd0; ln[1] = 2'd1; ln[2] = 2'd2; ln[3] = 2'd0; ln[4] = 2'd1; ln[5] = 2'd2;
    fs[0] = 1'b1; fs[1] = 1'b0; fs[2] = 1'b0; fs[3] = 1'b1; fs[4] = 1'b0; fs[5] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      send(w[k], fs[k], 1'b0, 2'd0);
      exp_lanes[ln[k]] = w[k];
      sbq.push_back(mk(4'b0001 << ln[k], 1'b0, k == 3, 1'b0));
      tick(e);
      vectors++;
      if (snap() !== e) begin
        miscompares++;
        $display("FAIL resync_w%0d: got %h expected %h", k, snap(), e);
      end
    end
    send(4'h6, 1'b0, 1'b0, 2'd0);
    exp_lanes[3] = 4'h6;
    sbq.push_back(mk(4'b1000, 1'b1, 1'b0, 1'b0));
    tick(e);
    vectors++;
    if (snap() !== e) begin
      miscompares++;
      $display("FAIL resync_close: got %h expected %h", snap(), e);
    end
  endtask

  task automatic test_mode_switch();
    send(4'h9, 1'b1, 1'b0, 2'd0);
    exp_lanes[0] = 4'h9;
    sbq.push_back(mk(4'b0001, 1'b0, 1'b0, 1'b0));
    send_check("switch_w0");
    send(4'hA, 1'b0, 1'b0, 2'd0);
    exp_lanes[1] = 4'hA;
    sbq.push_back(mk(4'b0010, 1'b0, 1'b0, 1'b0));
    send_check("switch_w1");
    send(4'hB, 1'b0, 1'b1, 2'd3);
    exp_lanes[3] = 4'hB;
    sbq.push_back(mk(4'b1000, 1'b0, 1'b0, 1'b0));
    send_check("switch_direct");
    send(4'hC, 1'b0, 1'b0, 2'd0);
    bump_drop();
    sbq.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0));
    send_check("switch_back_drop");
  endtask

  task automatic send_check(input string name);
    tick(e);
    vectors++;
    if (snap() !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, snap(), e);
    end
  endtask

  task automatic test_parity();
`ifdef TDM_DEMUX_PARITY_EN
    bad_par = 1'b1;
    send(4'b0111, 1'b0, 1'b1, 2'd0);
    exp_lanes[0] = 4'b0111;
    sbq.push_back(mk(4'b0001, 1'b0, 1'b0, 1'b1));
    tick(e);
    vectors++;
    if (snap() !== e) begin
      miscompares++;
      $display("FAIL parity_bad: got %h expected %h", snap(), e);
    end
    bad_par = 1'b0;
    send(4'b0111, 1'b0, 1'b1, 2'd0);
    sbq.push_back(mk(4'b0001, 1'b0, 1'b0, 1'b0));
    tick(e);
    vectors++;
    if (snap() !== e) begin
      miscompares++;
      $display("FAIL parity_good: got %h expected %h", snap(), e);
    end
    bad_par = 1'b1;
    send(4'b0001, 1'b0, 1'b0, 2'd0);
    bump_drop();
    sbq.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0));
    tick(e);
    vectors++;
    if (snap() !== e) begin
      miscompares++;
      $display("FAIL parity_dropped: got %h expected %h", snap(), e);
    end
    bad_par = 1'b0;
`endif
  endtask

  task automatic test_drops();
    for (int k = 0; k < 300; k++) begin
      send(4'(k), 1'b0, 1'b0, 2'(k));
      bump_drop();
      sbq.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0));
      tick(e);
      vectors++;
      if (snap() !== e) begin
        miscompares++;
        $display("FAIL drops_%0d: got %h expected %h", k, snap(), e);
      end
    end
    vectors++;
    if (drop_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL drops_saturate: got %0d expected 255", drop_cnt);
    end
  endtask

  initial begin
    in_valid    = 1'b0;
    in_data     = 4'h0;
    frame_start = 1'b0;
    mode        = 1'b0;
    sel         = 2'd0;
    bad_par     = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    in_parity   = 1'b0;
`endif
    for (int k = 0; k < 4; k++) exp_lanes[k] = 4'h0;
    exp_drop = 8'd0;
    test_reset();
    test_direct();
    test_frame();
    test_resync();
    test_mode_switch();
    test_parity();
    test_drops();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
